// File: rtl/mem_load_unit_if.sv
// Load-unit bus bundle: request inputs, memory read port and result outputs.
// slave = load unit side, master = requester / memory model side.
interface mem_load_unit_if #(
    parameter int DATA_W = 32
);
    logic              start;
    logic [DATA_W-1:0] addr;
    logic [1:0]        size;
    logic              signed_ld;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rd;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] ld_data;
    logic              busy;
    logic              done;
    logic              err;

    modport slave (
        input  start, addr, size, signed_ld, mem_rdata,
        output mem_rd, mem_addr, ld_data, busy, done, err
    );

    modport master (
        output start, addr, size, signed_ld, mem_rdata,
        input  mem_rd, mem_addr, ld_data, busy, done, err
    );
endinterface

// File: rtl/mem_load_unit.sv
// Memory load unit: aligned read, lane select, sign/zero extend.
// Ports: clk, reset (sync, active-high), bus (mem_load_unit_if.slave).
module mem_load_unit #(
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic           clk,
    input  logic           reset,
    mem_load_unit_if.slave bus
);
    localparam int OFF = $clog2(DATA_W / 8);
    localparam int CW  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(WAIT_CYCLES - 1);
    localparam logic [DATA_W-1:0] LOW_MSK = DATA_W'((DATA_W / 8) - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [OFF-1:0]    k_q, k_d;
    logic [1:0]        size_q, size_d;
    logic              sgn_q, sgn_d;
    logic              err_q, err_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] maddr_q, maddr_d;
    logic [DATA_W-1:0] ld_q, ld_d;

    logic              err_req;
    logic [DATA_W-1:0] sh;
    logic [DATA_W-1:0] msk;
    logic              msb;
    logic [DATA_W-1:0] ld_next;

    always_comb begin
        err_req = 1'b0;
        unique case (bus.size)
            2'b10:   err_req = bus.addr[0];
            2'b00:   err_req = (bus.addr[1:0] != 2'b00);
            2'b11:   err_req = (DATA_W == 32) || (bus.addr[2:0] != 3'b000);
            default: err_req = 1'b0;
        endcase
    end

    // Valid requests are naturally aligned, so shifting by 8*k lands
    // every size on bit 0; a dword always has k = 0.
    always_comb begin
        sh  = bus.mem_rdata >> {k_q, 3'b000};
        msk = '1;
        msb = 1'b0;
        unique case (size_q)
            2'b01: begin
                msk = DATA_W'(64'hFF);
                msb = sh[7];
            end
            2'b10: begin
                msk = DATA_W'(64'hFFFF);
                msb = sh[15];
            end
            2'b00: begin
                // On a 32-bit bus the mask is all ones, so sign is moot.
                msk = DATA_W'(64'hFFFF_FFFF);
                msb = sh[31];
            end
            default: begin
                msk = '1;
                msb = 1'b0;
            end
        endcase
        ld_next = (sh & msk) | ({DATA_W{sgn_q & msb}} & ~msk);
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        size_d  = size_q;
        sgn_d   = sgn_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        maddr_d = maddr_q;
        ld_d    = ld_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    k_d    = bus.addr[OFF-1:0];
                    size_d = bus.size;
                    sgn_d  = bus.signed_ld;
                    err_d  = err_req;
                    if (err_req) begin
                        state_d = DONE;
                    end else begin
                        state_d = REQ;
                        maddr_d = bus.addr & ~LOW_MSK;
                    end
                end
            end
            REQ: begin
                cnt_d   = CNT_INIT;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    ld_d    = ld_next;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            k_q     <= '0;
            size_q  <= '0;
            sgn_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            maddr_q <= '0;
            ld_q    <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            size_q  <= size_d;
            sgn_q   <= sgn_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            maddr_q <= maddr_d;
            ld_q    <= ld_d;
        end
    end

    assign bus.mem_rd   = (state_q == REQ);
    assign bus.mem_addr = maddr_q;
    assign bus.ld_data  = ld_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = (state_q == DONE);
    assign bus.err      = (state_q == DONE) && err_q;
endmodule
